led_pattern_ctrl: RTL and testbench
===================================

Name: led_pattern_ctrl

Overview:
- Downstream consumer of the board's period-divider toggle output.
- Treats every level change of the toggle as one step event and uses it to advance a multi-LED pattern: rotate-left, rotate-right, ping-pong or all-blink.
- Outputs drive the board LEDs directly.
- Also provides step and wrap strobes for later status logic.

Parameters:
- LED_NUM, 4, number of LEDs driven; legal range 2..16.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst  input  1  asynchronous active-high reset; asserting it immediately forces the reset values below.
- tog_in  input  1  toggle from divider; each level change (either direction) is one step; may be asynchronous to sys_clk.
- mode  input  2  pattern select: 0 rotate-left, 1 rotate-right, 2 ping-pong, 3 all-blink.
- pause  input  1  high = ignore step events; pattern holds.
- led_out  output  LED_NUM  LED drive; bit 0 = rightmost LED; 1 = lit.
- step_pulse  output  1  one-cycle strobe, high in the cycle in which led_out shows a newly applied step.
- wrap  output  1  one-cycle strobe, coincident with step_pulse, when a pattern period completes.

Behaviour:
- Reset values (immediate on sys_rst high, held while high):
  - led_out = 1 (bit 0 only).
  - step_pulse = 0, wrap = 0.
  - sync registers s1, s2, s3 = 0.
  - registered mode mode_q = 0.
  - direction state = LEFT.
- Input synchronisation:
  - tog_in passes through 2 flops (s1, s2); s3 holds the previous s2.
  - Internal step event ev = s2 XOR s3. s3 updates every cycle, regardless of pause.
- Latency: tog_in changes before rising edge k. Then ev is high after edge k+1, and led_out, step_pulse and wrap update at edge k+2.
- Applied step = ev AND NOT pause. Any non-applied cycle: led_out holds, step_pulse = 0, wrap = 0.
- Mode sampling: mode is sampled only on an applied step.
  - If mode != mode_q: mode_q <= mode and led_out loads the start pattern of the new mode; no advance; wrap = 0; step_pulse = 1.
  - Start patterns: mode 0 = bit 0; mode 1 = bit LED_NUM-1; mode 2 = bit 0 with direction LEFT; mode 3 = all ones.
- Advance rules (mode == mode_q):
  - mode 0: rotate left by 1; MSB wraps to bit 0. wrap = 1 when the new value is bit 0.
  - mode 1: rotate right by 1; bit 0 wraps to the MSB. wrap = 1 when the new value is the MSB.
  - mode 2 (FSM with states LEFT and RIGHT):
    - LEFT: shift left. If the new value is the MSB, go to RIGHT.
    - RIGHT: shift right. If the new value is bit 0, go to LEFT and set wrap = 1.
    - Period = 2*(LED_NUM-1) steps.
  - mode 3: led_out <= ~led_out. wrap = 1 when the new value is all ones (period = 2 steps).
- Direction state is only meaningful in mode 2; it is forced to LEFT on entry to mode 2.
- If led_out is ever not one-hot in modes 0..2 (not reachable from reset), the next applied step reloads the mode's start pattern.
- Simultaneous events:
  - Two tog_in edges closer than 2 clocks may merge or cancel; the divider guarantees periods far longer than this.
  - pause rising in the same cycle as ev: the step is dropped, not deferred.
- pause release: no burst, because edges during pause are consumed by s3.
- Reset release with tog_in high: the sync chain sees a 0->1 edge, giving exactly one applied step (if not paused) at the 3rd edge after release. This is required behaviour.
- Reset mid-pattern: the pattern restarts from the reset values; mode_q = 0. A non-zero mode is therefore loaded as a start pattern on the first applied step.

Test Plan:
- Reset, mode=0, pause=0, LED_NUM=4; toggle tog_in 5 times, 20 clocks apart -> led_out 0010, 0100, 1000, 0001, 0010; wrap only on the 0001 step; each change exactly 3 clock edges after the tog_in change, with step_pulse coincident.
- mode=2 from reset; 7 toggles -> 0001 (mode load), 0010, 0100, 1000, 0100, 0010, 0001; wrap only on the final step; no wrap on the 1000 reversal.
- mode=3 from reset: first toggle loads 1111 with wrap=0; next toggles give 0000, 1111 (wrap=1), 0000.
- mode=1 running at 0100; pause=1; 3 toggles -> led_out holds 0100, step_pulse stays 0; pause=0 with no further toggles -> no change; next toggle -> 0010.
- mode=0 at 0100; switch mode to 1 between toggles; next toggle -> 1000 (start pattern), wrap=0; following toggle -> 0100.
- Assert sys_rst mid-cycle (asynchronously, not on a clock edge) while led_out=1000 -> led_out=0001, step_pulse=0 immediately. Release with tog_in=1 -> exactly one step (led_out 0010) 3 edges after release.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: steps a multi-LED pattern on every level change of the
// divider toggle. Patterns are rotate-left, rotate-right, ping-pong and
// all-blink. It also gives a step strobe and a period-complete (wrap) strobe.
//
// Direction FSM (used only by ping-pong):
//   state     | meaning
//   DIR_LEFT  | lit LED moving toward the MSB
//   DIR_RIGHT | lit LED moving back toward bit 0
module led_pattern_ctrl #(
   parameter int LED_NUM = 4
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               tog_in,
   input  logic [1:0]         mode,
   input  logic               pause,
   output logic [LED_NUM-1:0] led_out,
   output logic               step_pulse,
   output logic               wrap
);

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_e;

   localparam logic [LED_NUM-1:0] PAT_LSB = {{(LED_NUM-1){1'b0}}, 1'b1};
   localparam logic [LED_NUM-1:0] PAT_MSB = {1'b1, {(LED_NUM-1){1'b0}}};
   localparam logic [LED_NUM-1:0] PAT_ALL = {LED_NUM{1'b1}};

   localparam logic [1:0] MODE_ROT_L = 2'd0;
   localparam logic [1:0] MODE_ROT_R = 2'd1;
   localparam logic [1:0] MODE_PONG  = 2'd2;
   localparam logic [1:0] MODE_BLINK = 2'd3;

   logic               s1_q, s2_q, s3_q;
   logic               ev;
   logic               applied;

   logic [LED_NUM-1:0] led_q, led_d;
   logic [1:0]         mode_q, mode_d;
   dir_e               dir_q, dir_d;
   logic               step_q, step_d;
   logic               wrap_q, wrap_d;

   logic [LED_NUM-1:0] led_dec;
   logic               led_onehot;

   // Start pattern loaded whenever a mode is (re)entered.
   function automatic logic [LED_NUM-1:0] start_pat(input logic [1:0] m);
      logic [LED_NUM-1:0] p;
      case (m)
         MODE_ROT_R: p = PAT_MSB;
         MODE_BLINK: p = PAT_ALL;
         default:    p = PAT_LSB;
      endcase
      return p;
   endfunction

   // Two-flop synchroniser plus history flop; s3 tracks s2 even while paused
   // so edges seen during pause are consumed instead of replayed later.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= tog_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign ev      = s2_q ^ s3_q;
   assign applied = ev & ~pause;

   // A corrupted (non one-hot) pattern in modes 0..2 is repaired on the next step.
   assign led_dec    = led_q - PAT_LSB;
   assign led_onehot = (led_q != '0) && ((led_q & led_dec) == '0);

   // Pattern, mode and direction state registers.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         led_q  <= PAT_LSB;
         mode_q <= MODE_ROT_L;
         dir_q  <= DIR_LEFT;
         step_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         led_q  <= led_d;
         mode_q <= mode_d;
         dir_q  <= dir_d;
         step_q <= step_d;
         wrap_q <= wrap_d;
      end
   end

   // Next pattern: mode change loads a start pattern, otherwise advance.
   always_comb begin
      led_d  = led_q;
      mode_d = mode_q;
      dir_d  = dir_q;
      step_d = 1'b0;
      wrap_d = 1'b0;

      if (applied) begin
         step_d = 1'b1;
         if (mode != mode_q) begin
            mode_d = mode;
            led_d  = start_pat(mode);
            dir_d  = DIR_LEFT;
         end else if ((mode_q != MODE_BLINK) && !led_onehot) begin
            led_d = start_pat(mode_q);
            dir_d = DIR_LEFT;
         end else begin
            case (mode_q)
               MODE_ROT_L: begin
                  led_d  = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
                  wrap_d = (led_d == PAT_LSB);
               end
               MODE_ROT_R: begin
                  led_d  = {led_q[0], led_q[LED_NUM-1:1]};
                  wrap_d = (led_d == PAT_MSB);
               end
               MODE_PONG: begin
                  if (dir_q == DIR_LEFT) begin
                     led_d = led_q << 1;
                     if (led_d == PAT_MSB) begin
                        dir_d = DIR_RIGHT;
                     end
                  end else begin
                     led_d = led_q >> 1;
                     if (led_d == PAT_LSB) begin
                        dir_d  = DIR_LEFT;
                        wrap_d = 1'b1;
                     end
                  end
               end
               default: begin
                  led_d  = ~led_q;
                  wrap_d = (led_d == PAT_ALL);
               end
            endcase
         end
      end
   end

   assign led_out    = led_q;
   assign step_pulse = step_q;
   assign wrap       = wrap_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed scenarios with literal expectations
// plus randomized toggles, mode changes, pauses and resets, compared every
// cycle against a phase-based model of the LED patterns.
module tb_led_pattern_ctrl;

   localparam int N = 4;

   logic         sys_clk = 1'b0;
   logic         sys_rst = 1'b1;
   logic         tog_in  = 1'b0;
   logic [1:0]   mode    = 2'd0;
   logic         pause   = 1'b0;
   logic [N-1:0] led_out;
   logic         step_pulse;
   logic         wrap;

   int n_assert = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   led_pattern_ctrl #(.LED_NUM(N)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .tog_in     (tog_in),
      .mode       (mode),
      .pause      (pause),
      .led_out    (led_out),
      .step_pulse (step_pulse),
      .wrap       (wrap)
   );

   initial forever #5 sys_clk = ~sys_clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Pattern is described by (mode, phase): phase is the lit index for the
   // rotations, position in the 2*(N-1) bounce cycle for ping-pong, and
   // on/off for blink.
   logic [1:0]   mode_m  = 2'd0;
   int           phase_m = 0;
   logic         step_m  = 1'b0;
   logic         wrap_m  = 1'b0;
   logic [N-1:0] led_m   = 1;
   logic [2:0]   smp     = 3'b000;

   function automatic logic [N-1:0] led_of(input logic [1:0] m, input int ph);
      logic [N-1:0] r;
      r = '0;
      case (m)
         2'd0, 2'd1: r[ph] = 1'b1;
         2'd2: begin
            if (ph < N) r[ph] = 1'b1;
            else        r[2*(N-1)-ph] = 1'b1;
         end
         default: r = (ph != 0) ? '1 : '0;
      endcase
      return r;
   endfunction

   function automatic int start_phase(input logic [1:0] m);
      case (m)
         2'd1:    return N-1;
         2'd3:    return 1;
         default: return 0;
      endcase
   endfunction

   initial forever begin
      logic ev;
      @(posedge sys_clk or posedge sys_rst);
      if (sys_rst) begin
         mode_m  = 2'd0;
         phase_m = 0;
         step_m  = 1'b0;
         wrap_m  = 1'b0;
         smp     = 3'b000;
      end else begin
         // a tog_in change sampled at edge m-2 is applied at edge m
         ev     = smp[1] ^ smp[2];
         smp    = {smp[1:0], tog_in};
         step_m = 1'b0;
         wrap_m = 1'b0;
         if (ev && !pause) begin
            step_m = 1'b1;
            if (mode != mode_m) begin
               mode_m  = mode;
               phase_m = start_phase(mode);
            end else begin
               case (mode_m)
                  2'd0: begin phase_m = (phase_m + 1) % N;         wrap_m = (phase_m == 0);   end
                  2'd1: begin phase_m = (phase_m + N - 1) % N;     wrap_m = (phase_m == N-1); end
                  2'd2: begin phase_m = (phase_m + 1) % (2*(N-1)); wrap_m = (phase_m == 0);   end
                  default: begin phase_m = 1 - phase_m;            wrap_m = (phase_m == 1);   end
               endcase
            end
         end
      end
      led_m = led_of(mode_m, phase_m);
   end

   // Cycle-by-cycle comparison against the model.
   initial forever begin
      @(negedge sys_clk);
      if (chk_en) begin
         check("model_led",  32'(led_out),    32'(led_m));
         check("model_step", 32'(step_pulse), 32'(step_m));
         check("model_wrap", 32'(wrap),       32'(wrap_m));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic do_reset(input logic [1:0] m);
      @(posedge sys_clk);
      #3;
      sys_rst = 1'b1;
      tog_in  = 1'b0;
      mode    = m;
      pause   = 1'b0;
      repeat (3) @(posedge sys_clk);
      #3 sys_rst = 1'b0;
      repeat (4) @(posedge sys_clk);
   endtask

   // Toggle, then verify no change at edge k+1 and the new state at edge k+2.
   task automatic tog_chk(input string nm, input logic [N-1:0] prev,
                          input logic [N-1:0] exp_led, input logic exp_step,
                          input logic exp_wrap);
      @(posedge sys_clk);
      #2 tog_in = ~tog_in;
      @(posedge sys_clk);
      @(posedge sys_clk);
      #1;
      check({nm, "_early_led"},  32'(led_out),    32'(prev));
      check({nm, "_early_step"}, 32'(step_pulse), 32'(0));
      @(posedge sys_clk);
      #1;
      check({nm, "_led"},  32'(led_out),    32'(exp_led));
      check({nm, "_step"}, 32'(step_pulse), 32'(exp_step));
      check({nm, "_wrap"}, 32'(wrap),       32'(exp_wrap));
      repeat (16) @(posedge sys_clk);
   endtask

   initial begin
      @(posedge sys_clk);
      #1;
      chk_en = 1'b1;
      check("rst_led",  32'(led_out),    32'h1);
      check("rst_step", 32'(step_pulse), 32'h0);
      check("rst_wrap", 32'(wrap),       32'h0);

      // rotate-left
      do_reset(2'd0);
      tog_chk("rl1", 4'b0001, 4'b0010, 1, 0);
      tog_chk("rl2", 4'b0010, 4'b0100, 1, 0);
      tog_chk("rl3", 4'b0100, 4'b1000, 1, 0);
      tog_chk("rl4", 4'b1000, 4'b0001, 1, 1);
      tog_chk("rl5", 4'b0001, 4'b0010, 1, 0);

      // ping-pong
      do_reset(2'd2);
      tog_chk("pp1", 4'b0001, 4'b0001, 1, 0);
      tog_chk("pp2", 4'b0001, 4'b0010, 1, 0);
      tog_chk("pp3", 4'b0010, 4'b0100, 1, 0);
      tog_chk("pp4", 4'b0100, 4'b1000, 1, 0);
      tog_chk("pp5", 4'b1000, 4'b0100, 1, 0);
      tog_chk("pp6", 4'b0100, 4'b0010, 1, 0);
      tog_chk("pp7", 4'b0010, 4'b0001, 1, 1);

      // all-blink
      do_reset(2'd3);
      tog_chk("bl1", 4'b0001, 4'b1111, 1, 0);
      tog_chk("bl2", 4'b1111, 4'b0000, 1, 0);
      tog_chk("bl3", 4'b0000, 4'b1111, 1, 1);
      tog_chk("bl4", 4'b1111, 4'b0000, 1, 0);

      // rotate-right with pause
      do_reset(2'd1);
      tog_chk("rr1", 4'b0001, 4'b1000, 1, 0);
      tog_chk("rr2", 4'b1000, 4'b0100, 1, 0);
      pause = 1'b1;
      tog_chk("ps1", 4'b0100, 4'b0100, 0, 0);
      tog_chk("ps2", 4'b0100, 4'b0100, 0, 0);
      tog_chk("ps3", 4'b0100, 4'b0100, 0, 0);
      #1 pause = 1'b0;
      repeat (10) @(posedge sys_clk);
      #1;
      check("unpause_led",  32'(led_out),    32'h4);
      check("unpause_step", 32'(step_pulse), 32'h0);
      tog_chk("rr3", 4'b0100, 4'b0010, 1, 0);

      // mode switch between toggles
      do_reset(2'd0);
      tog_chk("ms1", 4'b0001, 4'b0010, 1, 0);
      tog_chk("ms2", 4'b0010, 4'b0100, 1, 0);
      mode = 2'd1;
      tog_chk("ms3", 4'b0100, 4'b1000, 1, 0);
      tog_chk("ms4", 4'b1000, 4'b0100, 1, 0);

      // asynchronous reset mid-cycle, release with tog_in high
      do_reset(2'd0);
      tog_chk("ar1", 4'b0001, 4'b0010, 1, 0);
      tog_chk("ar2", 4'b0010, 4'b0100, 1, 0);
      tog_chk("ar3", 4'b0100, 4'b1000, 1, 0);
      @(posedge sys_clk);
      #3 sys_rst = 1'b1;
      #1;
      check("arst_led",  32'(led_out),    32'h1);
      check("arst_step", 32'(step_pulse), 32'h0);
      tog_in = 1'b1;
      repeat (2) @(posedge sys_clk);
      #3 sys_rst = 1'b0;
      @(posedge sys_clk);
      #1 check("rel_e1_step", 32'(step_pulse), 32'h0);
      @(posedge sys_clk);
      #1 check("rel_e2_led", 32'(led_out), 32'h1);
      @(posedge sys_clk);
      #1;
      check("rel_e3_led",  32'(led_out),    32'h2);
      check("rel_e3_step", 32'(step_pulse), 32'h1);
      repeat (10) @(posedge sys_clk);
      #1;
      check("rel_hold_led",  32'(led_out),    32'h2);
      check("rel_hold_step", 32'(step_pulse), 32'h0);

      // randomized traffic checked by the model
      do_reset(2'($urandom_range(0, 3)));
      for (int i = 0; i < 500; i++) begin
         int r;
         @(posedge sys_clk);
         #2;
         r = int'($urandom_range(0, 99));
         if (r < 55)      tog_in = ~tog_in;
         else if (r < 72) mode   = 2'($urandom_range(0, 3));
         else if (r < 88) pause  = ~pause;
         else if (r < 91) begin
            #1 sys_rst = 1'b1;
            tog_in = 1'($urandom_range(0, 1));
            repeat (int'($urandom_range(1, 2))) @(posedge sys_clk);
            #3 sys_rst = 1'b0;
         end
         repeat (int'($urandom_range(0, 6))) @(posedge sys_clk);
      end
      repeat (8) @(posedge sys_clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
